// File: rtl/nios2_seq_div_cell.sv
// Iterative radix-2 restoring divider for div/divu.
// One quotient bit per cycle. Fixed latency of DATA_W+2 cycles from the start
// strobe to the done pulse, independent of operand values.
module nios2_seq_div_cell #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              A_div_start,
   input  logic              A_div_signed,
   input  logic [DATA_W-1:0] A_div_src1,
   input  logic [DATA_W-1:0] A_div_src2,
   output logic              A_div_busy,
   output logic              A_div_done,
   output logic [DATA_W-1:0] A_div_quot,
   output logic [DATA_W-1:0] A_div_rem
);

   localparam int CNT_W = $clog2(DATA_W);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ITER  = 2'd1,
      S_FIXUP = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Magnitude of an operand; negative values only exist in signed mode.
   function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v,
                                             input logic                     sgn);
      logic [DATA_W-1:0] uv;
      uv = v;
      return (sgn && v[DATA_W-1]) ? -uv : uv;
   endfunction

   // Two's-complement negation applied only when the saved sign asks for it.
   function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v,
                                                    input logic              neg);
      return neg ? -v : v;
   endfunction

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]  p_q, p_d;        // partial remainder (always < divisor)
   logic [DATA_W-1:0]  q_q, q_d;        // dividend shifting out / quotient shifting in
   logic [DATA_W-1:0]  dvs_q, dvs_d;    // divisor magnitude
   logic [DATA_W-1:0]  raw_q, raw_d;    // raw dividend, returned on divide by zero
   logic               q_neg_q, q_neg_d;
   logic               r_neg_q, r_neg_d;
   logic               dz_q, dz_d;
   logic [DATA_W-1:0]  quot_q, quot_d;
   logic [DATA_W-1:0]  rem_q, rem_d;

   logic               accept;
   logic [DATA_W:0]    p_shift;
   logic [DATA_W-1:0]  q_shift;
   logic [DATA_W-1:0]  p_sub;
   logic               p_ge;

   // One restoring step: bring in the next dividend bit and trial-subtract.
   // The remainder always fits DATA_W bits after a step, so the difference
   // is computed modulo 2^DATA_W.
   assign p_shift = {p_q, q_q[DATA_W-1]};
   assign q_shift = {q_q[DATA_W-2:0], 1'b0};
   assign p_ge    = (p_shift >= {1'b0, dvs_q});
   assign p_sub   = p_shift[DATA_W-1:0] - dvs_q;

   assign accept  = A_div_start && ((state_q == S_IDLE) || (state_q == S_DONE));

   // Next-state, iteration datapath and result fixup.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      q_d     = q_q;
      dvs_d   = dvs_q;
      raw_d   = raw_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      dz_d    = dz_q;
      quot_d  = quot_q;
      rem_d   = rem_q;

      case (state_q)
         S_ITER: begin
            if (p_ge) begin
               p_d = p_sub;
               q_d = q_shift | DATA_W'(1);
            end else begin
               p_d = p_shift[DATA_W-1:0];
               q_d = q_shift;
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
               state_d = S_FIXUP;
            end
         end
         S_FIXUP: begin
            if (dz_q) begin
               quot_d = '1;
               rem_d  = raw_q;
            end else begin
               quot_d = apply_sign(q_q, q_neg_q);
               rem_d  = apply_sign(p_q, r_neg_q);
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Acceptance is shared by IDLE and DONE so back-to-back ops lose no cycle.
      if (accept) begin
         state_d = S_ITER;
         cnt_d   = CNT_W'(DATA_W - 1);
         p_d     = '0;
         q_d     = mag(A_div_src1, A_div_signed);
         dvs_d   = mag(A_div_src2, A_div_signed);
         raw_d   = A_div_src1;
         q_neg_d = A_div_signed && (A_div_src1[DATA_W-1] ^ A_div_src2[DATA_W-1]);
         r_neg_d = A_div_signed && A_div_src1[DATA_W-1];
         dz_d    = (A_div_src2 == '0);
      end
   end

   // Control state and visible results; reset aborts any op in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
      end
   end

   // Working datapath registers; only meaningful between accept and fixup.
   always_ff @(posedge clk) begin
      p_q     <= p_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      raw_q   <= raw_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
   end

   assign A_div_busy = (state_q == S_ITER) || (state_q == S_FIXUP);
   assign A_div_done = (state_q == S_DONE);
   assign A_div_quot = quot_q;
   assign A_div_rem  = rem_q;

endmodule

// File: doc/nios2_seq_div_cell.md
# nios2_seq_div_cell

Iterative 32-bit integer divider for the Nios II A-stage datapath. It is the inverse-operation companion to the pipelined multiply cell and serves `div`/`divu`. The block takes a dividend and divisor on a start strobe and runs a radix-2 restoring algorithm, one quotient bit per cycle. It returns quotient and remainder with a one-cycle done pulse at a fixed latency, so the pipeline stall logic can count cycles.

## Interface

Reset is synchronous and active-high; `clk` is the only clock.

Parameters:
- DATA_W, 32, operand/result width; iteration count = DATA_W; only 32 is verified.

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock domain
- A_div_start  in  1  request strobe; sampled only in IDLE or DONE
- A_div_signed  in  1  1 = signed (`div`), 0 = unsigned (`divu`); sampled with start
- A_div_src1  in  DATA_W  dividend; sampled with start
- A_div_src2  in  DATA_W  divisor; sampled with start
- A_div_busy  out  1  high in ITER and FIXUP
- A_div_done  out  1  one-cycle pulse, high in DONE
- A_div_quot  out  DATA_W  quotient; valid while done=1, held until next done
- A_div_rem  out  DATA_W  remainder; valid while done=1, held until next done

## Operation

- States:
  - IDLE: waiting for start.
  - ITER: 32 cycles, counter 31→0.
  - FIXUP: 1 cycle.
  - DONE: 1 cycle.
- Transitions:
  - IDLE/DONE + start → ITER.
  - DONE without start → IDLE.
  - ITER with count=0 → FIXUP.
  - FIXUP → DONE.
- Start acceptance: operands and signed flag are captured on the cycle start is accepted.
  - Signed mode: magnitudes of both operands are formed.
  - Saved signs: q_neg = s1^s2; r_neg = s1.
- ITER step:
  - partial remainder P (DATA_W+1 bits) = {P[DATA_W-1:0], Q[MSB]}.
  - Q shifts left.
  - If P ≥ |divisor|: P -= |divisor| and Q[0]=1; otherwise Q[0]=0.
- FIXUP:
  - Quotient is negated if q_neg; remainder is negated if r_neg.
  - Results are registered into A_div_quot/A_div_rem.
- Signed semantics: quotient truncates toward zero; remainder has the sign of the dividend; dividend = q*divisor + r.
- Divide by zero overrides the result in FIXUP, same latency: quot = all ones; rem = raw dividend, for both modes.
- Signed overflow (0x80000000 / 0xFFFFFFFF) has no special case: the algorithm yields quot = 0x80000000, rem = 0.
- Start while busy: ignored, with no effect on the operation in flight.
- Start in the DONE cycle: accepted; back-to-back throughput is one op per 34 cycles.
- Reset mid-operation: next cycle state = IDLE, busy = 0, done never pulses for the aborted op; outputs go to reset values.

## Timing

- Reset values: busy = 0, done = 0, quot = 0, rem = 0, state = IDLE, counter = 0.
- Start accepted at cycle 0:
  - busy = 1 during cycles 1–33.
  - done = 1 at cycle 34 only.
  - Latency 34 = DATA_W+2, independent of operand values.
- Outputs are registered; no combinational path from inputs to outputs.
- Operand inputs are don't-care except in the start-accept cycle.
- If reset and start are asserted in the same cycle, reset wins.

## Test plan

- Unsigned 100 / 7, start at cycle 0 → done only at cycle 34; quot = 14, rem = 2; busy high cycles 1–33.
- Signed −7 / 2 (0xFFFFFFF9 / 0x2) → quot = 0xFFFFFFFD, rem = 0xFFFFFFFF. Signed 7 / −2 → quot = 0xFFFFFFFD, rem = 1.
- 0x80000000 / 0xFFFFFFFF:
  - signed → quot = 0x80000000, rem = 0.
  - unsigned → quot = 0, rem = 0x80000000.
- Divide by zero, 5 / 0 in either mode → quot = 0xFFFFFFFF, rem = 5, done at cycle 34.
- Start 20/3 at cycle 0, then start 9/9 at cycle 10 (ignored):
  - done at 34 with quot = 6, rem = 2.
  - New start in cycle 34 (DONE) with 9/9 → done at 68, quot = 1, rem = 0.
- Reset asserted at cycle 10 of an op → busy = 0 at cycle 11, outputs 0, no done through cycle 40; new op afterwards completes normally.
